// File: rtl/vga_timing_out.sv
// 800x600 raster timing generator and VGA pin stage; sync/blank/frame marker are delayed PIPE+1 clocks to meet the returned pixel.
// Optional build macro VGA_TIMING_OUT_TEST_PATTERN_EN replaces pixel_rgb with eight vertical colour bars.
`timescale 1ns/1ps

module vga_timing_out #(
   parameter int   H_ACTIVE = 800,
   parameter int   H_FP     = 56,
   parameter int   H_SYNC   = 120,
   parameter int   H_BP     = 64,
   parameter int   V_ACTIVE = 600,
   parameter int   V_FP     = 37,
   parameter int   V_SYNC   = 6,
   parameter int   V_BP     = 23,
   parameter logic SYNC_POL = 1'b1,
   parameter int   PIPE     = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] pixel_rgb,
   output logic [9:0]  col,
   output logic [9:0]  row,
   output logic        hs,
   output logic        vs,
   output logic [3:0]  r,
   output logic [3:0]  g,
   output logic [3:0]  b,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   typedef struct packed {
      logic fs;
      logic de;
      logic hs;
      logic vs;
   } ctl_t;

   logic [10:0] h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic        fs_mark_q, fs_mark_d;

   ctl_t              ctl_now;
   ctl_t              ctl_tail;
   ctl_t [PIPE-1:0]   dly_q, dly_d;

   logic [11:0] pix_src;
   logic [11:0] rgb_q, rgb_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        fs_q, fs_d;

   // fs_mark is set only when the counters wrap into (0,0), so the
   // post-reset (0,0) never produces a frame_start pulse.
   always_comb begin
      h_cnt_d   = h_cnt_q + 11'd1;
      v_cnt_d   = v_cnt_q;
      fs_mark_d = 1'b0;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         if (v_cnt_q == V_LAST) begin
            v_cnt_d   = '0;
            fs_mark_d = 1'b1;
         end else begin
            v_cnt_d = v_cnt_q + 10'd1;
         end
      end
   end

   always_comb begin
      ctl_now.fs = fs_mark_q;
      ctl_now.de = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      ctl_now.hs = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
      ctl_now.vs = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
   end

   assign col = (h_cnt_q < H_ACT) ? h_cnt_q[9:0] : 10'd0;
   assign row = (v_cnt_q < V_ACT) ? v_cnt_q : 10'd0;

   always_comb begin
      dly_d[0] = ctl_now;
      for (int i = 1; i < PIPE; i++) begin
         dly_d[i] = dly_q[i-1];
      end
   end

   assign ctl_tail = dly_q[PIPE-1];

`ifdef VGA_TIMING_OUT_TEST_PATTERN_EN
   logic [PIPE-1:0][9:0] col_dly_q, col_dly_d;
   logic                 unused_pixel;

   function automatic logic [11:0] bar_colour(input logic [9:0] x);
      logic [11:0] c;
      if      (x < 10'd100) c = 12'hFFF;
      else if (x < 10'd200) c = 12'hFF0;
      else if (x < 10'd300) c = 12'h0FF;
      else if (x < 10'd400) c = 12'h0F0;
      else if (x < 10'd500) c = 12'hF0F;
      else if (x < 10'd600) c = 12'hF00;
      else if (x < 10'd700) c = 12'h00F;
      else                  c = 12'h000;
      return c;
   endfunction

   always_comb begin
      col_dly_d[0] = col;
      for (int i = 1; i < PIPE; i++) begin
         col_dly_d[i] = col_dly_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_dly_q <= '0;
      end else begin
         col_dly_q <= col_dly_d;
      end
   end

   assign unused_pixel = ^pixel_rgb;
   assign pix_src      = bar_colour(col_dly_q[PIPE-1]);
`else
   assign pix_src = pixel_rgb;
`endif

   // Blanking forces black no matter what the scene stage returns.
   always_comb begin
      rgb_d = ctl_tail.de ? pix_src : 12'h000;
      hs_d  = ctl_tail.hs ? SYNC_POL : ~SYNC_POL;
      vs_d  = ctl_tail.vs ? SYNC_POL : ~SYNC_POL;
      fs_d  = ctl_tail.fs;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         fs_mark_q <= 1'b0;
         dly_q     <= '0;
         rgb_q     <= 12'h000;
         hs_q      <= ~SYNC_POL;
         vs_q      <= ~SYNC_POL;
         fs_q      <= 1'b0;
      end else begin
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         fs_mark_q <= fs_mark_d;
         dly_q     <= dly_d;
         rgb_q     <= rgb_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         fs_q      <= fs_d;
      end
   end

   assign r           = rgb_q[11:8];
   assign g           = rgb_q[7:4];
   assign b           = rgb_q[3:0];
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign frame_start = fs_q;

endmodule
